fifo_wr_arbiter: RTL and testbench

FIFO_WR_ARBITER -- requirements
Module: fifo_wr_arbiter

---
 rtl/fifo_wr_arbiter_pkg.sv | 14 +
 rtl/fifo_wr_arbiter_rr_pick.sv | 33 +++
 rtl/fifo_wr_arbiter.sv | 102 ++++++++++
 tb/tb_fifo_wr_arbiter.sv | 132 +++++++++++++
 4 files changed

// File: rtl/fifo_wr_arbiter_pkg.sv
// Shared arbiter definitions: FSM encoding and default sizing, also used by
// the fifo_controller benches so both sides agree on widths.
package fifo_wr_arbiter_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } arb_state_e;

  localparam int N_REQ_DEF     = 4;
  localparam int DATA_W_DEF    = 8;
  localparam int BURST_MAX_DEF = 4;

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Combinational round-robin selector: first requester with req high searching
// from ptr+1 upward (mod N_REQ); returns one-hot winner, its index and valid.
module fifo_wr_arbiter_rr_pick #(
  parameter int N_REQ = 4,
  parameter int IW    = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic [N_REQ-1:0] req_i,
  input  logic [IW-1:0]    ptr_i,
  output logic [N_REQ-1:0] win_o,
  output logic [IW-1:0]    win_idx_o,
  output logic             vld_o
);

  int   idx;
  logic found;

  always_comb begin
    win_o     = '0;
    win_idx_o = '0;
    found     = 1'b0;
    idx       = 0;
    for (int k = 1; k <= N_REQ; k++) begin
      idx = (int'(ptr_i) + k) % N_REQ;
      if (!found && req_i[idx]) begin
        found      = 1'b1;
        win_o[idx] = 1'b1;
        win_idx_o  = IW'(idx);
      end
    end
    vld_o = found;
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter multiplexing N_REQ write requesters onto one FIFO write
// port; grants are bursts of up to BURST_MAX words, stalled by full.
module fifo_wr_arbiter
  import fifo_wr_arbiter_pkg::*;
#(
  parameter int N_REQ     = N_REQ_DEF,
  parameter int DATA_W    = DATA_W_DEF,
  parameter int BURST_MAX = BURST_MAX_DEF
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [N_REQ-1:0]        req,
  input  logic [N_REQ*DATA_W-1:0] din,
  output logic [N_REQ-1:0]        ack,
  output logic [N_REQ-1:0]        gnt,
  input  logic                    full,
  output logic                    wr,
  output logic [DATA_W-1:0]       w_data,
  output logic                    busy
);

  localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int BW = $clog2(BURST_MAX) + 1;
  localparam logic [BW-1:0] BURST_LAST = BW'(BURST_MAX - 1);

  arb_state_e        state_q, state_d;
  logic [N_REQ-1:0]  gnt_q, gnt_d;
  logic [IW-1:0]     own_q, own_d;
  logic [BW-1:0]     burst_q, burst_d;
  logic [IW-1:0]     rr_ptr_q, rr_ptr_d;

  logic [N_REQ-1:0]  pick_win;
  logic [IW-1:0]     pick_idx;
  logic              pick_vld;
  logic              own_req;

  fifo_wr_arbiter_rr_pick #(
    .N_REQ (N_REQ),
    .IW    (IW)
  ) u_rr_pick (
    .req_i     (req),
    .ptr_i     (rr_ptr_q),
    .win_o     (pick_win),
    .win_idx_o (pick_idx),
    .vld_o     (pick_vld)
  );

  always_comb begin
    state_d  = state_q;
    gnt_d    = gnt_q;
    own_d    = own_q;
    burst_d  = burst_q;
    rr_ptr_d = rr_ptr_q;
    wr       = 1'b0;
    ack      = '0;
    w_data   = '0;
    own_req  = req[own_q];

    if (state_q == ST_IDLE) begin
      if (pick_vld) begin
        state_d = ST_GRANT;
        gnt_d   = pick_win;
        own_d   = pick_idx;
        burst_d = '0;
      end
    end else begin
      // A reset arriving mid-burst must not let the current word through.
      wr = own_req & ~full & ~reset;
      if (wr) begin
        ack[own_q] = 1'b1;
        w_data     = din[int'(own_q)*DATA_W +: DATA_W];
        burst_d    = burst_q + 1'b1;
      end
      if (!own_req || (wr && burst_q == BURST_LAST)) begin
        state_d  = ST_IDLE;
        gnt_d    = '0;
        burst_d  = '0;
        rr_ptr_d = own_q;
      end
    end
  end

  assign gnt  = gnt_q;
  assign busy = (state_q == ST_GRANT) & ~reset;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      gnt_q    <= '0;
      own_q    <= '0;
      burst_q  <= '0;
      rr_ptr_q <= IW'(N_REQ - 1);
    end else begin
      state_q  <= state_d;
      gnt_q    <= gnt_d;
      own_q    <= own_d;
      burst_q  <= burst_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed-vector bench for fifo_wr_arbiter: bursts, round-robin order,
// full stalls, req drop under full and reset mid-burst.
module tb_fifo_wr_arbiter;

  logic        clk;
  logic        reset;
  logic [3:0]  req;
  logic [31:0] din;
  logic [3:0]  ack;
  logic [3:0]  gnt;
  logic        full;
  logic        wr;
  logic [7:0]  w_data;
  logic        busy;

  int vectors     = 0;
  int miscompares = 0;

  fifo_wr_arbiter #(
    .N_REQ     (4),
    .DATA_W    (8),
    .BURST_MAX (4)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .req    (req),
    .din    (din),
    .ack    (ack),
    .gnt    (gnt),
    .full   (full),
    .wr     (wr),
    .w_data (w_data),
    .busy   (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Inputs for this cycle are applied just after the edge; outputs are then
  // checked against the state registered at that edge.
  task automatic vec(input string tag, input logic rst, input logic [3:0] r,
                     input logic f, input logic [31:0] d, input logic [3:0] eg,
                     input logic ew, input logic [3:0] ea, input logic [7:0] ed);
    @(posedge clk);
    #1;
    reset = rst;
    req   = r;
    full  = f;
    din   = d;
    #1;
    chk({tag, ".gnt"},    32'(gnt),    32'(eg));
    chk({tag, ".wr"},     32'(wr),     32'(ew));
    chk({tag, ".ack"},    32'(ack),    32'(ea));
    chk({tag, ".w_data"}, 32'(w_data), 32'(ed));
    chk({tag, ".busy"},   32'(busy),   32'((|eg) & ~rst));
  endtask

  logic [31:0] dall;
  logic [3:0]  oh;
  int          o;

  initial begin
    reset = 1'b1;
    req   = '0;
    full  = 1'b0;
    din   = '0;

    // single requester: burst of 4, one idle gap, regrant
    vec("s1_rst",   1, 4'b0000, 0, 32'h0,  4'b0000, 0, 4'b0000, 8'h00);
    vec("s1_idle",  0, 4'b0001, 0, 32'hA0, 4'b0000, 0, 4'b0000, 8'h00);
    vec("s1_w0",    0, 4'b0001, 0, 32'hA0, 4'b0001, 1, 4'b0001, 8'hA0);
    vec("s1_w1",    0, 4'b0001, 0, 32'hA1, 4'b0001, 1, 4'b0001, 8'hA1);
    vec("s1_w2",    0, 4'b0001, 0, 32'hA2, 4'b0001, 1, 4'b0001, 8'hA2);
    vec("s1_w3",    0, 4'b0001, 0, 32'hA3, 4'b0001, 1, 4'b0001, 8'hA3);
    vec("s1_gap",   0, 4'b0001, 0, 32'hA4, 4'b0000, 0, 4'b0000, 8'h00);
    vec("s1_w4",    0, 4'b0001, 0, 32'hA4, 4'b0001, 1, 4'b0001, 8'hA4);
    vec("s1_w5",    0, 4'b0001, 0, 32'hA5, 4'b0001, 1, 4'b0001, 8'hA5);
    vec("s1_drop",  0, 4'b0000, 0, 32'hA5, 4'b0001, 0, 4'b0000, 8'h00);
    vec("s1_end",   0, 4'b0000, 0, 32'h0,  4'b0000, 0, 4'b0000, 8'h00);

    // all requesting: order 0,1,2,3,0 with one idle cycle between grants
    dall = 32'hD3C2B1A0;
    vec("s2_rst",   1, 4'b0000, 0, dall, 4'b0000, 0, 4'b0000, 8'h00);
    for (int g = 0; g < 5; g++) begin
      o  = g % 4;
      oh = 4'b0001 << o;
      vec("s2_gap", 0, 4'b1111, 0, dall, 4'b0000, 0, 4'b0000, 8'h00);
      for (int w = 0; w < 4; w++)
        vec("s2_w", 0, 4'b1111, 0, dall, oh, 1, oh, dall[o*8 +: 8]);
    end
    vec("s2_end",   0, 4'b0000, 0, dall, 4'b0000, 0, 4'b0000, 8'h00);

    // owner 2 stalled by full for 3 cycles after its 2nd word
    vec("s3_idle",  0, 4'b0100, 0, 32'h00210000, 4'b0000, 0, 4'b0000, 8'h00);
    vec("s3_w1",    0, 4'b0100, 0, 32'h00210000, 4'b0100, 1, 4'b0100, 8'h21);
    vec("s3_w2",    0, 4'b0100, 0, 32'h00220000, 4'b0100, 1, 4'b0100, 8'h22);
    vec("s3_st1",   0, 4'b0100, 1, 32'h00230000, 4'b0100, 0, 4'b0000, 8'h00);
    vec("s3_st2",   0, 4'b0100, 1, 32'h00230000, 4'b0100, 0, 4'b0000, 8'h00);
    vec("s3_st3",   0, 4'b0100, 1, 32'h00230000, 4'b0100, 0, 4'b0000, 8'h00);
    vec("s3_w3",    0, 4'b0100, 0, 32'h00230000, 4'b0100, 1, 4'b0100, 8'h23);
    vec("s3_w4",    0, 4'b0100, 0, 32'h00240000, 4'b0100, 1, 4'b0100, 8'h24);
    vec("s3_rel",   0, 4'b0000, 0, 32'h0,        4'b0000, 0, 4'b0000, 8'h00);

    // owner 1 drops req under full; search then restarts from 2 -> winner 3
    vec("s4_idle",  0, 4'b0010, 0, 32'h00001100, 4'b0000, 0, 4'b0000, 8'h00);
    vec("s4_w1",    0, 4'b0010, 0, 32'h00001100, 4'b0010, 1, 4'b0010, 8'h11);
    vec("s4_w2",    0, 4'b0010, 0, 32'h00001200, 4'b0010, 1, 4'b0010, 8'h12);
    vec("s4_drop",  0, 4'b0000, 1, 32'h0,        4'b0010, 0, 4'b0000, 8'h00);
    vec("s4_rel",   0, 4'b1001, 0, 32'h31000040, 4'b0000, 0, 4'b0000, 8'h00);

    // owner 3 reset during its 3rd write; next grant goes to 0
    vec("s5_w1",    0, 4'b1001, 0, 32'h31000040, 4'b1000, 1, 4'b1000, 8'h31);
    vec("s5_w2",    0, 4'b1001, 0, 32'h32000040, 4'b1000, 1, 4'b1000, 8'h32);
    vec("s5_rst",   1, 4'b1001, 0, 32'h33000040, 4'b1000, 0, 4'b0000, 8'h00);
    vec("s5_post",  0, 4'b1001, 0, 32'h33000040, 4'b0000, 0, 4'b0000, 8'h00);
    vec("s5_g0",    0, 4'b1001, 0, 32'h33000040, 4'b0001, 1, 4'b0001, 8'h40);
    vec("s5_drop",  0, 4'b0000, 0, 32'h0,        4'b0001, 0, 4'b0000, 8'h00);
    vec("s5_end",   0, 4'b0000, 0, 32'h0,        4'b0000, 0, 4'b0000, 8'h00);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
